// File: rtl/sobel_bus_pkg.sv
// sobel_bus_pkg: shared CSR map, status bit layout and sequencer state type
package sobel_bus_pkg;
    localparam logic [31:0] CSR_LED_ADDR    = 32'h00;
    localparam logic [31:0] CSR_SW_ADDR     = 32'h04;
    localparam logic [31:0] CSR_LEN_ADDR    = 32'h08;
    localparam logic [31:0] CSR_STATUS_ADDR = 32'h0C;
    localparam logic [31:0] CSR_CTRL_ADDR   = 32'h10;
    localparam logic [31:0] CSR_CYCLES_ADDR = 32'h14;
    localparam logic [31:0] DEADBEEF        = 32'hDEADBEEF;
    localparam int ST_IDLE_BIT = 0;
    localparam int ST_DONE_BIT = 1;
    localparam int ST_BUSY_BIT = 2;
    localparam int ST_ERR_BIT  = 3;
    typedef enum logic [1:0] {SEQ_IDLE, SEQ_START, SEQ_RUN} seq_state_t;
endpackage

// File: rtl/sobel_seq.sv
// sobel_seq: ap_ctrl_hs start sequencer with sticky done/err flags and run-cycle counter
// Ports: start_i/clear_i one-cycle pulses from CTRL writes; ap_ready_i/ap_done_i from the core;
// ap_start_o to the core; busy_o, done_o, err_o, cycles_o feed the STATUS and CYCLES registers.
module sobel_seq
    import sobel_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic        ap_ready_i,
    input  logic        ap_done_i,
    output logic        ap_start_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] cycles_o
);
    seq_state_t state;
    logic fin;
    always_comb fin = (state == SEQ_START && ap_ready_i && ap_done_i) || (state == SEQ_RUN && ap_done_i);
    assign busy_o = state != SEQ_IDLE;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= SEQ_IDLE;
            ap_start_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            cycles_o   <= '0;
        end else begin
            // a set arriving together with a clear must survive
            done_o <= fin | (done_o & ~clear_i);
            err_o  <= (start_i & busy_o) | (err_o & ~clear_i);
            if (busy_o)
                cycles_o <= (cycles_o == '1) ? cycles_o : cycles_o + 32'd1;
            case (state)
                SEQ_IDLE: if (start_i) begin
                    state      <= SEQ_START;
                    ap_start_o <= 1'b1;
                    cycles_o   <= '0;
                end
                SEQ_START: if (ap_ready_i) begin
                    ap_start_o <= 1'b0;
                    state      <= ap_done_i ? SEQ_IDLE : SEQ_RUN;
                end
                SEQ_RUN: if (ap_done_i) state <= SEQ_IDLE;
                default: begin
                    state      <= SEQ_IDLE;
                    ap_start_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/sobel_bus_ctrl.sv
// sobel_bus_ctrl: UDM bus slave decoding a CSR bank and test-memory port 0, sequencing the Sobel core
// Ports: bus_* UDM slave side; sw_i/led_o board IO; mem_* synchronous RAM port (1-cycle read latency);
// len_o run length to the core; ap_* core handshake; busy_o sequencer not idle.
module sobel_bus_ctrl
    import sobel_bus_pkg::*;
#(
    parameter logic [31:0] TESTMEM_ADDR  = 32'h80000000,
    parameter int          TESTMEM_WSIZE = 1024,
    parameter int          MEM_AW        = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [31:0]       bus_addr_bi,
    input  logic [3:0]        bus_be_bi,
    input  logic [31:0]       bus_wdata_bi,
    output logic              bus_ack_o,
    output logic              bus_resp_o,
    output logic [31:0]       bus_rdata_bo,
    input  logic [15:0]       sw_i,
    output logic [15:0]       led_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_bo,
    output logic [31:0]       mem_wdata_bo,
    input  logic [31:0]       mem_rdata_bi,
    output logic [31:0]       len_o,
    output logic              ap_start_o,
    input  logic              ap_ready_i,
    input  logic              ap_done_i,
    input  logic              ap_idle_i,
    output logic              busy_o
);
    localparam logic [32:0] MEM_END = {1'b0, TESTMEM_ADDR} + 33'(4 * TESTMEM_WSIZE);
    logic in_mem, csr_wr, start, clear, mem_rd1, mem_rd2, csr_resp, done, err;
    logic [31:0] status, csr_val, csr_rdata, cycles;
    assign in_mem    = bus_addr_bi >= TESTMEM_ADDR && {1'b0, bus_addr_bi} < MEM_END;
    // mem_rd1/mem_rd2 together form the pending-read window that stalls new requests
    assign bus_ack_o  = bus_req_i & ~(mem_rd1 | mem_rd2);
    assign csr_wr     = bus_ack_o & bus_we_i & ~in_mem;
    assign start      = csr_wr && bus_addr_bi == CSR_CTRL_ADDR && bus_wdata_bi[0];
    assign clear      = csr_wr && bus_addr_bi == CSR_CTRL_ADDR && bus_wdata_bi[1];
    assign bus_resp_o   = csr_resp | mem_rd2;
    assign bus_rdata_bo = mem_rd2 ? mem_rdata_bi : csr_resp ? csr_rdata : '0;
    always_comb begin
        status = '0;
        status[ST_ERR_BIT]  = err;
        status[ST_BUSY_BIT] = busy_o;
        status[ST_DONE_BIT] = done;
        status[ST_IDLE_BIT] = ap_idle_i;
        csr_val = bus_addr_bi == CSR_LED_ADDR    ? {16'h0, led_o} :
                  bus_addr_bi == CSR_SW_ADDR     ? {16'h0, sw_i}  :
                  bus_addr_bi == CSR_LEN_ADDR    ? len_o          :
                  bus_addr_bi == CSR_STATUS_ADDR ? status         :
                  bus_addr_bi == CSR_CTRL_ADDR   ? 32'h0          :
                  bus_addr_bi == CSR_CYCLES_ADDR ? cycles         : DEADBEEF;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            led_o        <= '0;
            len_o        <= '0;
            mem_we_o     <= 1'b0;
            mem_addr_bo  <= '0;
            mem_wdata_bo <= '0;
            mem_rd1      <= 1'b0;
            mem_rd2      <= 1'b0;
            csr_resp     <= 1'b0;
            csr_rdata    <= '0;
        end else begin
            mem_we_o  <= bus_ack_o & in_mem & bus_we_i;
            mem_rd1   <= bus_ack_o & in_mem & ~bus_we_i;
            mem_rd2   <= mem_rd1;
            csr_resp  <= bus_ack_o & ~in_mem & ~bus_we_i;
            csr_rdata <= csr_val;
            if (bus_ack_o & in_mem)
                mem_addr_bo <= bus_addr_bi[MEM_AW+1:2];
            if (bus_ack_o & in_mem & bus_we_i)
                mem_wdata_bo <= bus_wdata_bi;
            if (csr_wr && bus_addr_bi == CSR_LED_ADDR)
                for (int i = 0; i < 2; i++)
                    if (bus_be_bi[i]) led_o[8*i +: 8] <= bus_wdata_bi[8*i +: 8];
            if (csr_wr && bus_addr_bi == CSR_LEN_ADDR)
                for (int i = 0; i < 4; i++)
                    if (bus_be_bi[i]) len_o[8*i +: 8] <= bus_wdata_bi[8*i +: 8];
        end
    end
    sobel_seq u_seq (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start),
        .clear_i    (clear),
        .ap_ready_i (ap_ready_i),
        .ap_done_i  (ap_done_i),
        .ap_start_o (ap_start_o),
        .busy_o     (busy_o),
        .done_o     (done),
        .err_o      (err),
        .cycles_o   (cycles)
    );
endmodule

// File: doc/sobel_bus_ctrl.md
# sobel_bus_ctrl

Bus slave and accelerator sequencer between the UDM debug bus master and the Sobel HLS core. Decodes UDM requests into a CSR bank (LED, SW, LEN, STATUS, CTRL, CYCLES) and port 0 of the image test memory. Drives the core's ap_ctrl_hs start handshake and captures completion status plus a run-cycle count, so the host can launch a run and poll for the result over UART.

## Interface
Parameters:
- TESTMEM_ADDR, 32'h80000000, byte base address of the test memory window
- TESTMEM_WSIZE, 1024, test memory size in 32-bit words
- MEM_AW, 10, test memory word-address width; clog2(TESTMEM_WSIZE)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, synchronous, active-low
- bus_req_i  in  1  UDM request strobe
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_bi  in  32  byte address
- bus_be_bi  in  4  byte enables
- bus_wdata_bi  in  32  write data
- bus_ack_o  out  1  request accepted
- bus_resp_o  out  1  read response valid, one-cycle pulse
- bus_rdata_bo  out  32  read data, valid with bus_resp_o
- sw_i  in  16  board switches
- led_o  out  16  board LEDs
- mem_we_o  out  1  test memory port 0 write enable
- mem_addr_bo  out  MEM_AW  test memory port 0 word address
- mem_wdata_bo  out  32  test memory port 0 write data
- mem_rdata_bi  in  32  test memory port 0 read data; synchronous RAM, 1-cycle latency
- len_o  out  32  LEN register, passed to the core
- ap_start_o  out  1  core start
- ap_ready_i, ap_done_i, ap_idle_i  in  1 each  core handshake outputs
- busy_o  out  1  sequencer not idle

## Operation
- Register map:
  - 0x00 LED, RW, bits [15:0]
  - 0x04 SW, RO
  - 0x08 LEN, RW
  - 0x0C STATUS, RO: {28'b0, err, busy, done, ap_idle_i}
  - 0x10 CTRL, WO: bit0 start, bit1 clear done/err
  - 0x14 CYCLES, RO
- Memory window: TESTMEM_ADDR ≤ addr < TESTMEM_ADDR + 4·TESTMEM_WSIZE. Word address is addr[MEM_AW+1:2]. Word access only; bus_be_bi is ignored for memory.
- LED and LEN writes honour bus_be_bi per byte.
- Writes to RO or unmapped addresses are dropped.
- Reads of unmapped addresses respond with 32'hDEADBEEF, so the UDM never times out.
- Sequencer FSM, states IDLE, START, RUN:
  - IDLE: a CTRL.start write moves to START and clears CYCLES to 0.
  - START: ap_start_o = 1. On ap_ready_i with ap_done_i, go to IDLE and set done. On ap_ready_i alone, go to RUN.
  - RUN: on ap_done_i, go to IDLE and set done.
- Start written while not IDLE: ignored, sets err.
- CYCLES increments every cycle in START or RUN and saturates at 32'hFFFFFFFF.
- done is sticky. If done-set and clear occur in the same cycle, set wins.
- busy_o = (state != IDLE).

## Timing
- bus_ack_o = bus_req_i & ~rd_pend. rd_pend is high from an accepted memory read until its response.
- CSR read: bus_resp_o one cycle after the accepted request.
- Memory read: mem_addr_bo is registered at accept (cycle 1). RAM data arrives cycle 2. bus_resp_o and bus_rdata_bo = mem_rdata_bi in cycle 2, i.e. two cycles after accept.
- Memory write: mem_we_o, mem_addr_bo and mem_wdata_bo are registered and pulse for exactly one cycle after accept. No response is generated for writes.
- CSR write takes effect on the cycle after accept. A start write makes ap_start_o high on that same next cycle.
- ap_start_o drops the cycle after ap_ready_i is sampled high.
- bus_rdata_bo is 0 when bus_resp_o = 0.
- Reset values:
  - All outputs 0, including led_o and len_o.
  - FSM in IDLE; done, err and CYCLES all 0.
- Reset asserted mid-run: FSM returns to IDLE, ap_start_o drops on the next edge, and any pending read response is discarded.

## Structure
- Package sobel_bus_pkg holds:
  - address constants: CSR_LED_ADDR, CSR_SW_ADDR, CSR_LEN_ADDR, CSR_STATUS_ADDR, CSR_CTRL_ADDR, CSR_CYCLES_ADDR
  - the DEADBEEF constant
  - the state enum
  - STATUS bit indices
- Sub-module sobel_seq holds the FSM, done/err flags and the cycle counter. Its inputs are start/clear pulses and the ap_* handshake signals.
- The top level holds bus decode, CSR storage and the response mux.

## Test plan
- Write 0x00 = 0x0000A5A5 with be = 4'b0001, then read 0x00 → led_o = 0x00A5; response 0x000000A5 exactly one cycle after ack.
- Write 0x80000010 = 0x12345678, read it back → mem_we_o pulses with mem_addr_bo = 4; bus_resp_o two cycles after ack with 0x12345678; bus_ack_o low while the read is pending.
- Start with the core model asserting ap_ready after 3 cycles and ap_done after 20 → ap_start_o high for exactly 4 cycles; STATUS = 0x2 (done) after completion; CYCLES = 24.
- Write start again while in RUN → state unchanged, STATUS.err = 1; then write CTRL = 0x2 → STATUS.done = 0 and STATUS.err = 0.
- Read 0x00000100 → 0xDEADBEEF. Assert rst_n_i low during RUN → next cycle ap_start_o = 0, busy_o = 0, led_o = 0, CYCLES = 0.
